// File: rtl/baccarat_round_ctrl_if.sv
// Card dealer handshake: the round controller (master) requests, the dealer (slave) supplies a rank.
interface baccarat_round_ctrl_if;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_in;

  modport master (output card_req, input card_valid, input card_in);
  modport slave  (input card_req, output card_valid, output card_in);
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals six card slots, applies third-card rules, declares the winner.
// Optional win/tie tally counters are built when BACC_TALLY_EN is defined.
module baccarat_round_ctrl #(
  parameter int unsigned PAUSE_CYCLES = 0
) (
  input  logic                  slow_clock,
  input  logic                  reset,
  input  logic                  start,
  baccarat_round_ctrl_if.master card,
  output logic [3:0]            pcard1,
  output logic [3:0]            pcard2,
  output logic [3:0]            pcard3,
  output logic [3:0]            dcard1,
  output logic [3:0]            dcard2,
  output logic [3:0]            dcard3,
  input  logic [3:0]            pscore,
  input  logic [3:0]            dscore,
  output logic                  busy,
  output logic                  done,
  output logic                  player_win,
  output logic                  banker_win
`ifdef BACC_TALLY_EN
  ,
  output logic [7:0]            player_tally,
  output logic [7:0]            banker_tally,
  output logic [7:0]            tie_tally
`endif
);

  typedef enum logic [3:0] {
    IDLE, REQ_P1, REQ_D1, REQ_P2, REQ_D2, EVAL,
    REQ_P3, DECIDE_D3, REQ_D3, RESULT, DONE, PAUSE
  } state_e;

  localparam bit         HAS_PAUSE  = (PAUSE_CYCLES != 0);
  localparam logic [7:0] PAUSE_LOAD = HAS_PAUSE ? 8'(PAUSE_CYCLES - 1) : 8'd0;

  state_e          state_q, state_d, ret_q, ret_d;
  logic [7:0]      pause_q, pause_d;
  logic [5:0][3:0] card_q, card_d;  // slots 0..2 player, 3..5 banker
  logic            pwin_q, pwin_d, bwin_q, bwin_d;
  logic            accept, is_req, banker_draw;
  logic [3:0]      p3v;

  function automatic state_e after_card(input state_e s);
    case (s)
      REQ_P1:  return REQ_D1;
      REQ_D1:  return REQ_P2;
      REQ_P2:  return REQ_D2;
      REQ_D2:  return EVAL;
      REQ_P3:  return DECIDE_D3;
      REQ_D3:  return RESULT;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [2:0] slot_of(input state_e s);
    case (s)
      REQ_P1:  return 3'd0;
      REQ_P2:  return 3'd1;
      REQ_P3:  return 3'd2;
      REQ_D1:  return 3'd3;
      REQ_D2:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  assign is_req = (state_q == REQ_P1) || (state_q == REQ_D1) || (state_q == REQ_P2) ||
                  (state_q == REQ_D2) || (state_q == REQ_P3) || (state_q == REQ_D3);
  assign accept = is_req && card.card_valid && (card.card_in >= 4'd1) && (card.card_in <= 4'd13);
  assign p3v    = (card_q[2] > 4'd9) ? 4'd0 : card_q[2];

  always_comb begin
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (p3v != 4'd8);
      4'd4:             banker_draw = (p3v >= 4'd2) && (p3v <= 4'd7);
      4'd5:             banker_draw = (p3v >= 4'd4) && (p3v <= 4'd7);
      4'd6:             banker_draw = (p3v >= 4'd6) && (p3v <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first so no latch can be inferred.
    state_d = state_q;
    ret_d   = ret_q;
    pause_d = pause_q;
    card_d  = card_q;
    pwin_d  = pwin_q;
    bwin_d  = bwin_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          card_d  = '0;
          pwin_d  = 1'b0;
          bwin_d  = 1'b0;
          state_d = REQ_P1;
        end
      end
      REQ_P1, REQ_D1, REQ_P2, REQ_D2, REQ_P3, REQ_D3: begin
        if (accept) begin
          card_d[slot_of(state_q)] = card.card_in;
          if (HAS_PAUSE) begin
            state_d = PAUSE;
            ret_d   = after_card(state_q);
            pause_d = PAUSE_LOAD;
          end else begin
            state_d = after_card(state_q);
          end
        end
      end
      PAUSE: begin
        if (pause_q == 8'd0) state_d = ret_q;
        else                 pause_d = pause_q - 8'd1;
      end
      EVAL: begin
        if ((pscore == 4'd8) || (pscore == 4'd9) || (dscore == 4'd8) || (dscore == 4'd9))
          state_d = RESULT;
        else if (pscore <= 4'd5)
          state_d = REQ_P3;
        else if (dscore <= 4'd5)
          state_d = REQ_D3;
        else
          state_d = RESULT;
      end
      DECIDE_D3: state_d = banker_draw ? REQ_D3 : RESULT;
      RESULT: begin
        pwin_d  = (pscore >= dscore);
        bwin_d  = (dscore >= pscore);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      pause_q <= 8'd0;
      card_q  <= '0;
      pwin_q  <= 1'b0;
      bwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pause_q <= pause_d;
      card_q  <= card_d;
      pwin_q  <= pwin_d;
      bwin_q  <= bwin_d;
    end
  end

  assign card.card_req = is_req;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign player_win    = pwin_q;
  assign banker_win    = bwin_q;
  assign pcard1        = card_q[0];
  assign pcard2        = card_q[1];
  assign pcard3        = card_q[2];
  assign dcard1        = card_q[3];
  assign dcard2        = card_q[4];
  assign dcard3        = card_q[5];

`ifdef BACC_TALLY_EN
  logic [7:0] ptally_q, btally_q, ttally_q;

  // Only reset clears the tallies; a new round leaves them alone.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      ptally_q <= 8'd0;
      btally_q <= 8'd0;
      ttally_q <= 8'd0;
    end else if (state_q == RESULT) begin
      if (pscore == dscore) begin
        if (ttally_q != 8'hFF) ttally_q <= ttally_q + 8'd1;
      end else if (pscore > dscore) begin
        if (ptally_q != 8'hFF) ptally_q <= ptally_q + 8'd1;
      end else begin
        if (btally_q != 8'hFF) btally_q <= btally_q + 8'd1;
      end
    end
  end

  assign player_tally = ptally_q;
  assign banker_tally = btally_q;
  assign tie_tally    = ttally_q;
`endif

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Directed bench for baccarat_round_ctrl: one instance with no pause, one with a 3-cycle pause.
// Tally checks are compiled in when BACC_TALLY_EN is defined.
module tb_baccarat_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst0, start0, rst1, start1;
  logic [3:0] pc0 [3];
  logic [3:0] dc0 [3];
  logic [3:0] pc1 [3];
  logic [3:0] dc1 [3];
  logic [3:0] ps0, ds0, ps1, ds1;
  logic       busy0, done0, pw0, bw0, busy1, done1, pw1, bw1;

  baccarat_round_ctrl_if u_if0 ();
  baccarat_round_ctrl_if u_if1 ();

  function automatic int card_val(input logic [3:0] c);
    return (c > 4'd9) ? 0 : int'(c);
  endfunction

  // Behavioural external scorer: modulo-10 total, faces count zero.
  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return 4'((card_val(a) + card_val(b) + card_val(c)) % 10);
  endfunction

  assign ps0 = hand_score(pc0[0], pc0[1], pc0[2]);
  assign ds0 = hand_score(dc0[0], dc0[1], dc0[2]);
  assign ps1 = hand_score(pc1[0], pc1[1], pc1[2]);
  assign ds1 = hand_score(dc1[0], dc1[1], dc1[2]);

`ifdef BACC_TALLY_EN
  logic [7:0] pt0, bt0, tt0, pt1, bt1, tt1;
`endif

  baccarat_round_ctrl #(.PAUSE_CYCLES(0)) u_dut0 (
    .slow_clock(clk), .reset(rst0), .start(start0), .card(u_if0.master),
    .pcard1(pc0[0]), .pcard2(pc0[1]), .pcard3(pc0[2]),
    .dcard1(dc0[0]), .dcard2(dc0[1]), .dcard3(dc0[2]),
    .pscore(ps0), .dscore(ds0), .busy(busy0), .done(done0),
    .player_win(pw0), .banker_win(bw0)
`ifdef BACC_TALLY_EN
    , .player_tally(pt0), .banker_tally(bt0), .tie_tally(tt0)
`endif
  );

  baccarat_round_ctrl #(.PAUSE_CYCLES(3)) u_dut1 (
    .slow_clock(clk), .reset(rst1), .start(start1), .card(u_if1.master),
    .pcard1(pc1[0]), .pcard2(pc1[1]), .pcard3(pc1[2]),
    .dcard1(dc1[0]), .dcard2(dc1[1]), .dcard3(dc1[2]),
    .pscore(ps1), .dscore(ds1), .busy(busy1), .done(done1),
    .player_win(pw1), .banker_win(bw1)
`ifdef BACC_TALLY_EN
    , .player_tally(pt1), .banker_tally(bt1), .tie_tally(tt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0][3:0] mk_deck(input logic [3:0] c0, input logic [3:0] c1,
                                              input logic [3:0] c2, input logic [3:0] c3,
                                              input logic [3:0] c4, input logic [3:0] c5);
    logic [5:0][3:0] d;
    d[0] = c0; d[1] = c1; d[2] = c2; d[3] = c3; d[4] = c4; d[5] = c5;
    return d;
  endfunction

  // Plays one round on instance 0, dealing deck cards in order whenever a card is requested.
  task automatic run_round(input logic [5:0][3:0] deck, output int used, output int cyc);
    logic req_seen;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    used = 0;
    cyc  = 0;
    while (!done0 && cyc < 60) begin
      req_seen = u_if0.card_req;
      if (req_seen && used < 6) begin
        u_if0.card_valid = 1'b1;
        u_if0.card_in    = deck[used];
      end else begin
        u_if0.card_valid = 1'b0;
      end
      tick();
      if (req_seen && u_if0.card_valid) used++;
      cyc++;
    end
    u_if0.card_valid = 1'b0;
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL round_timeout: done=%b after %0d cycles, required 1", done0, cyc);
    end
  endtask

  task automatic check_result(input string name, input int used, input int exp_used,
                              input logic [3:0] exp_p3, input logic [3:0] exp_d3,
                              input logic exp_pw, input logic exp_bw);
    checks++;
    if (used != exp_used) begin
      errors++;
      $display("FAIL %s cards: got %0d required %0d", name, used, exp_used);
    end
    checks++;
    if (pc0[2] !== exp_p3 || dc0[2] !== exp_d3) begin
      errors++;
      $display("FAIL %s third: got p3=%0d d3=%0d required p3=%0d d3=%0d", name, pc0[2], dc0[2], exp_p3, exp_d3);
    end
    checks++;
    if (pw0 !== exp_pw || bw0 !== exp_bw) begin
      errors++;
      $display("FAIL %s lights: got pw=%b bw=%b required pw=%b bw=%b", name, pw0, bw0, exp_pw, exp_bw);
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL %s status: got busy=%b done=%b required busy=0 done=1", name, busy0, done0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({pc0[0], pc0[1], pc0[2], dc0[0], dc0[1], dc0[2]} !== 24'd0 ||
        u_if0.card_req !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || pw0 !== 1'b0 || bw0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got req=%b busy=%b done=%b pw=%b bw=%b p1=%0d required all zero",
               u_if0.card_req, busy0, done0, pw0, bw0, pc0[0]);
    end
  endtask

  task automatic test_mid_round_reset();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    u_if0.card_valid = 1'b1;
    u_if0.card_in    = 4'd5;
    tick();
    // Start while busy must be ignored.
    start0        = 1'b1;
    u_if0.card_in = 4'd3;
    tick();
    start0 = 1'b0;
    u_if0.card_valid = 1'b0;
    checks++;
    if (pc0[0] !== 4'd5 || dc0[0] !== 4'd3 || u_if0.card_req !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: got p1=%0d d1=%0d req=%b busy=%b required p1=5 d1=3 req=1 busy=1",
               pc0[0], dc0[0], u_if0.card_req, busy0);
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    checks++;
    if (pc0[0] !== 4'd0 || dc0[0] !== 4'd0 || u_if0.card_req !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL abort: got p1=%0d d1=%0d req=%b busy=%b done=%b required all zero",
               pc0[0], dc0[0], u_if0.card_req, busy0, done0);
    end
  endtask

  task automatic test_natural();
    int used, cyc;
    run_round(mk_deck(4'd9, 4'd10, 4'd13, 4'd2, 4'd0, 4'd0), used, cyc);
    check_result("natural", used, 4, 4'd0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL natural_latency: got %0d cycles required 6", cyc);
    end
    checks++;
    if (pc0[0] !== 4'd9 || dc0[0] !== 4'd10 || pc0[1] !== 4'd13 || dc0[1] !== 4'd2) begin
      errors++;
      $display("FAIL natural_cards: got %0d %0d %0d %0d required 9 10 13 2", pc0[0], dc0[0], pc0[1], dc0[1]);
    end
    repeat (3) tick();
    checks++;
    if (done0 !== 1'b1 || pw0 !== 1'b1 || pc0[0] !== 4'd9) begin
      errors++;
      $display("FAIL done_hold: got done=%b pw=%b p1=%0d required 1 1 9", done0, pw0, pc0[0]);
    end
  endtask

  task automatic test_third_cards();
    int used, cyc;
    run_round(mk_deck(4'd2, 4'd3, 4'd1, 4'd10, 4'd8, 4'd0), used, cyc);
    check_result("d3_stand_p8", used, 5, 4'd8, 4'd0, 1'b0, 1'b1);
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL p3_latency: got %0d cycles required 8", cyc);
    end
    run_round(mk_deck(4'd1, 4'd2, 4'd2, 4'd3, 4'd5, 4'd4), used, cyc);
    check_result("d3_draw_d5", used, 6, 4'd5, 4'd4, 1'b0, 1'b1);
    checks++;
    if (cyc != 9) begin
      errors++;
      $display("FAIL six_card_latency: got %0d cycles required 9", cyc);
    end
    run_round(mk_deck(4'd2, 4'd1, 4'd1, 4'd4, 4'd12, 4'd3), used, cyc);
    check_result("d3_stand_face", used, 5, 4'd12, 4'd0, 1'b0, 1'b1);
    run_round(mk_deck(4'd3, 4'd1, 4'd4, 4'd2, 4'd7, 4'd0), used, cyc);
    check_result("player_stands_banker_draws", used, 5, 4'd0, 4'd7, 1'b1, 1'b0);
  endtask

  task automatic test_stand_and_tie();
    int used, cyc;
    run_round(mk_deck(4'd4, 4'd6, 4'd2, 4'd1, 4'd0, 4'd0), used, cyc);
    check_result("both_stand", used, 4, 4'd0, 4'd0, 1'b0, 1'b1);
    run_round(mk_deck(4'd3, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0), used, cyc);
    check_result("tie", used, 4, 4'd0, 4'd0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_beats_start();
    start0 = 1'b1;
    rst0   = 1'b1;
    tick();
    start0 = 1'b0;
    rst0   = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || u_if0.card_req !== 1'b0 || pw0 !== 1'b0 || pc0[0] !== 4'd0) begin
      errors++;
      $display("FAIL reset_vs_start: got busy=%b done=%b req=%b pw=%b p1=%0d required all zero",
               busy0, done0, u_if0.card_req, pw0, pc0[0]);
    end
  endtask

  task automatic test_pause();
    int n;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    u_if1.card_valid = 1'b1;
    u_if1.card_in    = 4'd0;
    tick();
    checks++;
    if (u_if1.card_req !== 1'b1 || pc1[0] !== 4'd0) begin
      errors++;
      $display("FAIL bad_card_0: got req=%b p1=%0d required req=1 p1=0", u_if1.card_req, pc1[0]);
    end
    u_if1.card_in = 4'd15;
    tick();
    checks++;
    if (u_if1.card_req !== 1'b1 || pc1[0] !== 4'd0) begin
      errors++;
      $display("FAIL bad_card_15: got req=%b p1=%0d required req=1 p1=0", u_if1.card_req, pc1[0]);
    end
    u_if1.card_in = 4'd7;
    tick();
    n = 0;
    while (u_if1.card_req !== 1'b1 && n < 10) begin
      n++;
      tick();
    end
    u_if1.card_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL pause_len: got %0d idle cycles required 3", n);
    end
    checks++;
    if (pc1[0] !== 4'd7 || dc1[0] !== 4'd0) begin
      errors++;
      $display("FAIL pause_cards: got p1=%0d d1=%0d required p1=7 d1=0", pc1[0], dc1[0]);
    end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
  endtask

`ifdef BACC_TALLY_EN
  task automatic test_tally();
    int used, cyc;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 256; i++) run_round(mk_deck(4'd9, 4'd10, 4'd13, 4'd2, 4'd0, 4'd0), used, cyc);
    checks++;
    if (pt0 !== 8'd255 || bt0 !== 8'd0 || tt0 !== 8'd0) begin
      errors++;
      $display("FAIL tally_sat: got p=%0d b=%0d t=%0d required 255 0 0", pt0, bt0, tt0);
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if (pt0 !== 8'd255 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL tally_start: got p=%0d busy=%b required 255 1", pt0, busy0);
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    run_round(mk_deck(4'd3, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0), used, cyc);
    checks++;
    if (pt0 !== 8'd0 || bt0 !== 8'd0 || tt0 !== 8'd1) begin
      errors++;
      $display("FAIL tally_tie: got p=%0d b=%0d t=%0d required 0 0 1", pt0, bt0, tt0);
    end
  endtask
`endif

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    u_if0.card_valid = 1'b0; u_if0.card_in = 4'd0;
    u_if1.card_valid = 1'b0; u_if1.card_in = 4'd0;
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0;
    test_reset();
    test_mid_round_reset();
    test_natural();
    test_third_cards();
    test_stand_and_tie();
    test_reset_beats_start();
    test_pause();
`ifdef BACC_TALLY_EN
    test_tally();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baccarat_round_ctrl.md
Name: baccarat_round_ctrl

Overview:
- Sequencer for one baccarat round. It requests cards from the card source and loads them into six card registers (player 1-3, banker 1-3).
- The register contents feed two external hand scorers (modulo-10, face cards score 0). The returned totals drive the third-card decisions.
- On completion the block declares player win, banker win or tie (both lights).
- Sits between the card dealer and the score/display datapath.

Parameters:
PAUSE_CYCLES, 0, idle cycles inserted after each accepted card before the next request (0..255).

Ports:
- slow_clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a round when in IDLE or DONE, ignored otherwise
- card_req  out  1  high while waiting for a card
- card_valid  in  1  card_in is valid this cycle
- card_in  in  4  card rank 1..13 (1=A, 11..13=J,Q,K)
- pcard1, pcard2, pcard3  out  4 each  player card registers; 0 = empty
- dcard1, dcard2, dcard3  out  4 each  banker card registers; 0 = empty
- pscore  in  4  player total from external scorer (0..9)
- dscore  in  4  banker total from external scorer (0..9)
- busy  out  1  high from the start acceptance until DONE
- done  out  1  high in DONE state
- player_win  out  1  valid only while done=1
- banker_win  out  1  valid only while done=1; both high = tie

Behaviour:
- Reset: state IDLE; all card registers 0; card_req, busy, done, player_win and banker_win all 0; pause counter 0. Reset mid-round aborts immediately to this condition.
- States: IDLE, REQ_P1, REQ_D1, REQ_P2, REQ_D2, EVAL, REQ_P3, DECIDE_D3, REQ_D3, RESULT, DONE, plus PAUSE (returns to the next REQ state).
- start in IDLE or DONE:
  - clear all six card registers
  - clear the win lights
  - set busy
  - enter REQ_P1 the next cycle
- REQ_x state:
  - card_req=1.
  - Acceptance cycle: card_valid=1 and card_in in 1..13. card_in is written to the target register on that edge, and card_req drops the next cycle.
  - card_valid=1 with card_in of 0, 14 or 15 is discarded; stay in REQ_x with card_req held high.
- After each accepted card:
  - if PAUSE_CYCLES>0, spend exactly PAUSE_CYCLES cycles in PAUSE with card_req=0
  - otherwise go directly to the next state
- EVAL: entered one cycle after the 4th card loads, so the scorers have settled.
  - pscore or dscore in 8..9 (natural) → RESULT.
  - Otherwise, pscore<=5 → REQ_P3.
  - Otherwise (player stands), dscore<=5 → REQ_D3, else → RESULT.
- DECIDE_D3: entered one cycle after pcard3 loads. Let p3v = 0 if pcard3>9, else pcard3. Banker draws when:
  - dscore 0..2: always
  - dscore 3: p3v!=8
  - dscore 4: p3v in 2..7
  - dscore 5: p3v in 4..7
  - dscore 6: p3v in 6..7
  - dscore 7: never
  - Draw → REQ_D3; otherwise → RESULT.
- RESULT: entered one cycle after the last card loads.
  - Compare pscore and dscore and register player_win=(pscore>=dscore), banker_win=(dscore>=pscore).
  - Next state DONE.
- DONE:
  - done=1, busy=0
  - card registers and lights hold until start or reset
- start asserted while busy: ignored. start and reset together: reset wins.
- Scores are only sampled in EVAL, DECIDE_D3 and RESULT. Out-of-range score inputs (>9) are treated per the comparisons above with no special handling.
- Round latency with PAUSE_CYCLES=0 and card_valid always high: 4 to 6 card cycles, plus EVAL, DECIDE_D3 (if used) and RESULT.

Optional Feature:
Macro BACC_TALLY_EN.
- Defined:
  - adds outputs player_tally[7:0], banker_tally[7:0] and tie_tally[7:0], all reset to 0
  - on the RESULT→DONE transition exactly one counter increments (tie counts only in tie_tally)
  - counters saturate at 255
  - counters are cleared only by reset, not by start
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted during REQ_P2 after P1=5 and D1=3 loaded → next cycle IDLE, all cards 0, card_req=0, busy=0.
- Cards 9,10,K,2 (pscore=9, dscore=2) → natural; no third requests; pcard3=dcard3=0; player_win=1, banker_win=0.
- Cards 2,3,1,10 (p=3, d=3) then p3=8 → banker stands (dscore 3, p3v=8); result p=1, d=3, banker_win=1 only.
- Cards 4,6,2,1 (p=6 stands, d=7) → no draws; banker_win=1; then cards 3,2,3,4 (p=6, d=6) → tie, both lights=1.
- PAUSE_CYCLES=3 with card_in=0 and card_valid=1 during REQ_P1 → value ignored, card_req stays 1; after a valid card, card_req=0 for exactly 3 cycles.
- BACC_TALLY_EN defined: 256 consecutive player wins → player_tally=255, other tallies 0; start does not clear them.
